rtc_bus_ctrl: RTL and testbench



---
 rtl/rtc_pkg.sv | 67 ++++++
 rtl/rtc_phase_timer.sv | 34 +++
 rtl/rtc_bus_ctrl.sv | 141 ++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// ============================================================================
// Module      : rtc_pkg
// Description : Port ids, bus timing and FSM encoding for the RTC bus stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rtc_pkg;

    localparam logic [7:0] P_ADDR   = 8'h01;
    localparam logic [7:0] P_WDATA  = 8'h02;
    localparam logic [7:0] P_RCMD   = 8'h03;
    localparam logic [7:0] P_RDATA  = 8'h04;
    localparam logic [7:0] P_STATUS = 8'h05;

    localparam int T_SETUP = 2;
    localparam int T_PULSE = 10;
    localparam int T_HOLD  = 2;
    localparam int T_GAP   = 4;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    localparam int TMR_W = $clog2(max_of4(T_SETUP, T_PULSE, T_HOLD, T_GAP) + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_A_SETUP = 3'd1;
    localparam logic [2:0] S_A_PULSE = 3'd2;
    localparam logic [2:0] S_A_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_D_SETUP = 3'd5;
    localparam logic [2:0] S_D_PULSE = 3'd6;
    localparam logic [2:0] S_D_HOLD  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_A_SETUP = S_A_SETUP,
        ST_A_PULSE = S_A_PULSE,
        ST_A_HOLD  = S_A_HOLD,
        ST_GAP     = S_GAP,
        ST_D_SETUP = S_D_SETUP,
        ST_D_PULSE = S_D_PULSE,
        ST_D_HOLD  = S_D_HOLD
    } state_t;

    // Timer reload for a state: it terminates after (value + 1) clocks.
    function automatic logic [TMR_W-1:0] state_ticks(input state_t s);
        logic [TMR_W-1:0] t;
        case (s)
            ST_A_SETUP, ST_D_SETUP: t = TMR_W'(T_SETUP - 1);
            ST_A_PULSE, ST_D_PULSE: t = TMR_W'(T_PULSE - 1);
            ST_A_HOLD,  ST_D_HOLD:  t = TMR_W'(T_HOLD - 1);
            ST_GAP:                 t = TMR_W'(T_GAP - 1);
            default:                t = '0;
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_phase_timer.sv
// ============================================================================
// Module      : rtc_phase_timer
// Description : Loadable down-counter with terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign tc = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/rtc_bus_ctrl.sv
// ============================================================================
// Module      : rtc_bus_ctrl
// Description : Turns micro port writes into timed RTC address/data bus cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bus_ctrl
    import rtc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] out_port,
    input  logic [7:0] dir,
    input  logic       actRTC,
    input  logic       writestrobe,
    input  logic       read_strobe,
    output logic [7:0] in_portRTC,
    output logic       busy,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_sel,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    state_t             r_state;
    state_t             w_next;
    logic               r_err;
    logic               r_is_read;
    logic [7:0]         r_addr;
    logic [7:0]         r_wdata;
    logic [7:0]         r_rdata;
    logic               w_wr_acc;
    logic               w_start;
    logic               w_tc;
    logic               w_load;
    logic [TMR_W-1:0]   w_load_val;
    logic               w_is_read_nxt;
    logic               w_a_phase;
    logic               w_d_phase;

    assign w_wr_acc = writestrobe && actRTC;
    assign w_start  = w_wr_acc && !busy && (dir == P_WDATA || dir == P_RCMD);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_start) w_next = ST_A_SETUP;
            ST_A_SETUP: if (w_tc)    w_next = ST_A_PULSE;
            ST_A_PULSE: if (w_tc)    w_next = ST_A_HOLD;
            ST_A_HOLD:  if (w_tc)    w_next = ST_GAP;
            ST_GAP:     if (w_tc)    w_next = ST_D_SETUP;
            ST_D_SETUP: if (w_tc)    w_next = ST_D_PULSE;
            ST_D_PULSE: if (w_tc)    w_next = ST_D_HOLD;
            ST_D_HOLD:  if (w_tc)    w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    // Every state change reloads the timer with the duration of the state entered.
    assign w_load     = (w_next != r_state);
    assign w_load_val = state_ticks(w_next);

    assign w_is_read_nxt = (r_state == ST_IDLE) ? (dir == P_RCMD) : r_is_read;
    assign w_a_phase = (w_next == ST_A_SETUP) || (w_next == ST_A_PULSE) || (w_next == ST_A_HOLD);
    assign w_d_phase = (w_next == ST_D_SETUP) || (w_next == ST_D_PULSE) || (w_next == ST_D_HOLD);

    rtc_phase_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .tc       (w_tc)
    );

    // Bus outputs are decoded from the next state so they are registered with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            busy       <= 1'b0;
            r_is_read  <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= 8'h00;
            r_wdata    <= 8'h00;
            r_rdata    <= 8'h00;
            cs_n       <= 1'b1;
            wr_n       <= 1'b1;
            rd_n       <= 1'b1;
            ad_sel     <= 1'b0;
            ad_oe      <= 1'b0;
            ad_out     <= 8'h00;
            in_portRTC <= 8'h00;
        end else begin
            r_state   <= w_next;
            busy      <= (w_next != ST_IDLE);
            r_is_read <= w_is_read_nxt;

            if (w_wr_acc && !busy) begin
                if (dir == P_ADDR)  r_addr  <= out_port;
                if (dir == P_WDATA) r_wdata <= out_port;
            end

            if (w_wr_acc && busy) begin
                r_err <= 1'b1;
            end else if (read_strobe && actRTC && dir == P_STATUS) begin
                r_err <= 1'b0;
            end

            if (r_state == ST_D_PULSE && w_tc && r_is_read) begin
                r_rdata <= ad_in;
            end

            cs_n   <= !(w_a_phase || w_d_phase);
            wr_n   <= !((w_next == ST_A_PULSE) || (w_next == ST_D_PULSE && !w_is_read_nxt));
            rd_n   <= !(w_next == ST_D_PULSE && w_is_read_nxt);
            ad_sel <= w_d_phase;
            ad_oe  <= w_a_phase || (w_d_phase && !w_is_read_nxt);
            if (w_a_phase) begin
                ad_out <= r_addr;
            end else if (w_d_phase && !w_is_read_nxt) begin
                ad_out <= r_wdata;
            end else begin
                ad_out <= 8'h00;
            end

            case (dir)
                P_RDATA:  in_portRTC <= r_rdata;
                P_STATUS: in_portRTC <= {6'b0, r_err, busy};
                default:  in_portRTC <= 8'h00;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_ctrl.sv
// ============================================================================
// Module      : tb_rtc_bus_ctrl
// Description : Scoreboard bench for rtc_bus_ctrl bus phases, busy and reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtc_bus_ctrl;

    localparam logic [7:0] C_ADDR   = 8'h01;
    localparam logic [7:0] C_WDATA  = 8'h02;
    localparam logic [7:0] C_RCMD   = 8'h03;
    localparam logic [7:0] C_RDATA  = 8'h04;
    localparam logic [7:0] C_STATUS = 8'h05;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] out_port = 8'h00;
    logic [7:0] dir = 8'h00;
    logic       actRTC = 1'b0;
    logic       writestrobe = 1'b0;
    logic       read_strobe = 1'b0;
    logic [7:0] in_portRTC;
    logic       busy;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_sel;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;
    logic [7:0] bus_val = 8'h37;

    // The RTC only drives the bus while it sees its read strobe.
    assign ad_in = rd_n ? 8'h00 : bus_val;

    rtc_bus_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .out_port    (out_port),
        .dir         (dir),
        .actRTC      (actRTC),
        .writestrobe (writestrobe),
        .read_strobe (read_strobe),
        .in_portRTC  (in_portRTC),
        .busy        (busy),
        .cs_n        (cs_n),
        .rd_n        (rd_n),
        .wr_n        (wr_n),
        .ad_sel      (ad_sel),
        .ad_out      (ad_out),
        .ad_oe       (ad_oe),
        .ad_in       (ad_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cs;
        int         wr;
        int         rd;
        logic       sel;
        logic       oe;
        logic [7:0] dat;
        int         gap;
    } phase_t;

    typedef struct {
        int len;
        int lo;
    } busy_t;

    phase_t     phase_q[$];
    busy_t      busy_q[$];
    logic [7:0] read_q[$];
    int         tests = 0;
    int         fails = 0;
    int         viol = 0;

    // ------------------------------------------------------------------ stimulus helpers
    task automatic push_txn(input logic is_read, input logic [7:0] addr,
                            input logic [7:0] wdata, input int lo);
        phase_t p;
        busy_t  b;
        p = '{cs: 14, wr: 10, rd: 0, sel: 1'b0, oe: 1'b1, dat: addr, gap: 0};
        phase_q.push_back(p);
        if (is_read) p = '{cs: 14, wr: 0, rd: 10, sel: 1'b1, oe: 1'b0, dat: 8'h00, gap: 4};
        else         p = '{cs: 14, wr: 10, rd: 0, sel: 1'b1, oe: 1'b1, dat: wdata, gap: 4};
        phase_q.push_back(p);
        b = '{len: 32, lo: lo};
        busy_q.push_back(b);
    endtask

    task automatic wr_now(input logic [7:0] p, input logic [7:0] d, input logic act);
        dir = p;
        out_port = d;
        actRTC = act;
        writestrobe = 1'b1;
        @(posedge clk); #1;
        writestrobe = 1'b0;
        actRTC = 1'b0;
    endtask

    task automatic wr_port(input logic [7:0] p, input logic [7:0] d);
        @(posedge clk); #1;
        wr_now(p, d, 1'b1);
    endtask

    task automatic rd_port(input logic [7:0] p, input logic [7:0] expv);
        @(posedge clk); #1;
        dir = p;
        actRTC = 1'b1;
        @(posedge clk); #1;
        read_q.push_back(expv);
        read_strobe = 1'b1;
        @(posedge clk); #1;
        read_strobe = 1'b0;
        actRTC = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        logic [21:0] act;
        logic [21:0] req;
        act = {cs_n, rd_n, wr_n, ad_sel, ad_oe, busy, ad_out, in_portRTC};
        req = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: {cs_n,rd_n,wr_n,ad_sel,ad_oe,busy,ad_out,in_port}=%h required %h",
                     name, act, req);
        end
    endtask

    // ------------------------------------------------------------------ monitor
    initial begin : monitor
        int         cs_len, wr_len, rd_len, gap_cur, gap_start, bz_len, lo_len, lo_start;
        logic       f_sel, f_oe;
        logic [7:0] f_dat;
        bit         stable;
        phase_t     e;
        busy_t      b;
        logic [7:0] r;
        cs_len = 0; wr_len = 0; rd_len = 0; gap_cur = 0; gap_start = 0;
        bz_len = 0; lo_len = 0; lo_start = 0;
        f_sel = 1'b0; f_oe = 1'b0; f_dat = 8'h00; stable = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                cs_len = 0; wr_len = 0; rd_len = 0; gap_cur = 0; bz_len = 0; lo_len = 0;
            end else begin
                if ((!wr_n && !rd_n) || ((!wr_n || !rd_n) && cs_n)) viol++;
                if (!cs_n) begin
                    if (cs_len == 0) begin
                        gap_start = gap_cur;
                        f_sel = ad_sel; f_oe = ad_oe; f_dat = ad_out; stable = 1'b1;
                    end else if (ad_sel !== f_sel || ad_oe !== f_oe || (f_oe && ad_out !== f_dat)) begin
                        stable = 1'b0;
                    end
                    cs_len++;
                    if (!wr_n) wr_len++;
                    if (!rd_n) rd_len++;
                    gap_cur = 0;
                end else begin
                    if (cs_len > 0) begin
                        tests++;
                        if (phase_q.size() == 0) begin
                            fails++;
                            $display("FAIL phase_unexpected: cs_len=%0d sel=%b, required no bus cycle", cs_len, f_sel);
                        end else begin
                            e = phase_q.pop_front();
                            if (cs_len != e.cs || wr_len != e.wr || rd_len != e.rd || f_sel !== e.sel ||
                                f_oe !== e.oe || !stable || gap_start != e.gap || (e.oe && f_dat !== e.dat)) begin
                                fails++;
                                $display("FAIL phase: cs=%0d wr=%0d rd=%0d sel=%b oe=%b dat=%h gap=%0d stable=%0d, required cs=%0d wr=%0d rd=%0d sel=%b oe=%b dat=%h gap=%0d stable=1",
                                         cs_len, wr_len, rd_len, f_sel, f_oe, f_dat, gap_start, stable,
                                         e.cs, e.wr, e.rd, e.sel, e.oe, e.dat, e.gap);
                            end
                        end
                    end
                    cs_len = 0; wr_len = 0; rd_len = 0;
                    gap_cur = busy ? gap_cur + 1 : 0;
                end
                if (busy) begin
                    if (bz_len == 0) lo_start = lo_len;
                    bz_len++;
                end else begin
                    if (bz_len > 0) begin
                        tests++;
                        if (busy_q.size() == 0) begin
                            fails++;
                            $display("FAIL busy_unexpected: busy run of %0d, required none", bz_len);
                        end else begin
                            b = busy_q.pop_front();
                            if (bz_len != b.len || (b.lo >= 0 && lo_start != b.lo)) begin
                                fails++;
                                $display("FAIL busy: len=%0d idle_before=%0d, required len=%0d idle_before=%0d",
                                         bz_len, lo_start, b.len, b.lo);
                            end
                        end
                        lo_len = 0;
                    end
                    bz_len = 0;
                    lo_len++;
                end
                if (read_strobe && actRTC) begin
                    tests++;
                    if (read_q.size() == 0) begin
                        fails++;
                        $display("FAIL read_unexpected: in_portRTC=%h", in_portRTC);
                    end else begin
                        r = read_q.pop_front();
                        if (in_portRTC !== r) begin
                            fails++;
                            $display("FAIL read dir=%h: in_portRTC=%h required %h", dir, in_portRTC, r);
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------ directed sequence
    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("reset_values");

        // 1: reset during the address strobe
        wr_port(C_ADDR, 8'h11);
        wr_port(C_WDATA, 8'h33);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("reset_abort");
        rd_port(C_STATUS, 8'h00);

        // 2: write transaction
        wr_port(C_ADDR, 8'h21);
        push_txn(1'b0, 8'h21, 8'h45, -1);
        wr_port(C_WDATA, 8'h45);
        wait_idle("t2_idle");

        // 3: read transaction
        bus_val = 8'h37;
        wr_port(C_ADDR, 8'h22);
        push_txn(1'b1, 8'h22, 8'h00, -1);
        wr_port(C_RCMD, 8'h00);
        wait_idle("t3_idle");
        rd_port(C_RDATA, 8'h37);

        // 4: write while busy is ignored and flags err
        push_txn(1'b0, 8'h22, 8'h5A, -1);
        wr_port(C_WDATA, 8'h5A);
        wr_port(C_WDATA, 8'hA5);
        rd_port(C_STATUS, 8'h03);
        wait_idle("t4_idle");
        rd_port(C_STATUS, 8'h00);

        // 5: back-to-back read accepted the cycle busy drops
        bus_val = 8'h5C;
        push_txn(1'b1, 8'h22, 8'h00, -1);
        wr_port(C_RCMD, 8'h00);
        wait_idle("t5_idle");
        push_txn(1'b1, 8'h22, 8'h00, 1);
        wr_now(C_RCMD, 8'h00, 1'b1);
        wait_idle("t5_idle2");
        rd_port(C_STATUS, 8'h00);
        rd_port(C_RDATA, 8'h5C);

        // 6: write strobe outside the RTC decode
        @(posedge clk); #1;
        wr_now(C_WDATA, 8'hEE, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rd_port(C_STATUS, 8'h00);

        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (phase_q.size() != 0 || busy_q.size() != 0 || read_q.size() != 0) begin
            fails++;
            $display("FAIL pending: phase=%0d busy=%0d read=%0d outstanding, required 0 0 0",
                     phase_q.size(), busy_q.size(), read_q.size());
        end
        tests++;
        if (viol != 0) begin
            fails++;
            $display("FAIL strobe_rules: %0d violating cycles, required 0", viol);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #100000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
